maior_stream: RTL
=================

Name: maior_stream

Overview:
Sequential max-finder for 8-bit sample streams. Accepts samples one per cycle over a valid/ready handshake and groups them into blocks of GROUP samples. For each block it emits the maximum value and the in-block index of that maximum over an output valid/ready handshake. Its output feeds any consumer that expects one registered max per block, replacing a wide parallel comparator tree with one comparator and a counter.

Parameters:
- WIDTH, 8, sample and result width in bits.
- GROUP, 4, samples per block; legal range is 1 to 256.
- IDXW, $clog2(GROUP) with a minimum of 1, width of out_idx.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a sample.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  WIDTH  sample value, unsigned.
- out_valid  out  1  out_max and out_idx hold a completed block result.
- out_ready  in  1  consumer accepts the result.
- out_max  out  WIDTH  maximum of the block.
- out_idx  out  IDXW  position (0..GROUP-1) of the maximum within the block.

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_max=0, out_idx=0, internal count=0, running max=0, state=ACCUM. In ACCUM, in_ready=1 immediately after reset.
- Transfer rule: a transfer happens when valid&&ready are both high on a rising edge. A producer may not drop in_valid or change in_data before the transfer; the block itself does not check this.
- Comparison: unsigned compare. A new sample replaces the running max only if running_max < sample, so on ties the earliest index is kept. The first sample of each block always loads unconditionally.
- States:
  - ACCUM: in_ready=1; out_valid=0.
    - Each accepted sample updates the running max/idx and increments count.
    - Accepting the sample at count==GROUP-1 does three things on the same edge: registers out_max/out_idx from the final compare (including that last sample), clears count to 0, and moves to HOLD.
  - HOLD: out_valid=1; out_max/out_idx stay stable until the output transfer; in_ready=out_ready.
    - Output transfer with no input transfer -> ACCUM.
    - Output transfer together with an input transfer (zero-bubble) -> the sample loads as index 0 of the next block and count becomes 1. The state then goes to ACCUM, or stays in HOLD with the new result when GROUP==1.
    - out_ready=0 -> stall: no input accepted and no output state changes.
- Latency: result is visible the cycle after the last sample is accepted. Sustained throughput is one sample per cycle when out_ready stays high.
- Wrap: count runs 0..GROUP-1 and then returns to 0. It never reaches GROUP.
- Reset mid-block: the partial block is discarded; the first sample after reset is index 0.
- GROUP==1: every sample is its own result with out_idx=0.

Optional Feature:
- Macro MAIOR_STREAM_MIN_EN.
- Defined: adds output ports out_min (WIDTH) and out_min_idx (IDXW). These are tracked in parallel using sample < running_min, with ties keeping the earliest index. They are reset to 0 and registered and held under the same rules as out_max/out_idx.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package maior_pkg holds:
  - state enum {ACCUM, HOLD};
  - default WIDTH and GROUP constants;
  - a function computing IDXW with the minimum of 1.
- Sub-module cmp_maior (combinational, parameterised by WIDTH). Inputs: current value and index, new value and index. Outputs: winner value and index. It uses the strict less-than rule. A second instance is used for min when MAIOR_STREAM_MIN_EN is defined.

Test Plan:
- Max tracking, out_ready=1: feed 5,6,7,3 -> out_max=7, out_idx=2, out_valid high for exactly 1 cycle, starting one cycle after the sample 3 is accepted.
- Ties: feed 10,6,10,7 -> out_max=10, out_idx=0. Then back-to-back 10,15,7,20 -> out_max=20, out_idx=3, with in_ready never dropping.
- Backpressure: hold out_ready=0 after block 9,1,1,1 completes -> in_ready=0, result stays 9/idx 0 for 5 cycles. Raise out_ready with in_valid high -> result taken and the next sample is accepted on the same edge.
- Reset mid-block: feed 200,201, then pulse rst asynchronously between clock edges -> outputs go to 0 immediately. Then feed 1,2,3,4 -> out_max=4, out_idx=3.
- Edge values with GROUP=1: feed 0,255,0 -> results 0,255,0, each with idx 0.
- With MIN_EN: feed 5,6,7,3 -> out_min=3, out_min_idx=3.

Source files
------------

// File: rtl/maior_stream_pkg.sv
// maior_pkg: shared types and constants for the maior_stream sample max-finder.
//   state_t    : two-state controller encoding (ACCUM collects a block, HOLD presents its result)
//   DEF_WIDTH  : default sample width in bits
//   DEF_GROUP  : default number of samples per block
//   idx_width  : width of an in-block index, never narrower than one bit
package maior_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_GROUP = 4;

  // A block of one sample still needs a one-bit index port.
  function automatic int idx_width(input int group);
    return (group <= 1) ? 1 : $clog2(group);
  endfunction

endpackage

// File: rtl/maior_stream_cmp.sv
// cmp_maior: single combinational comparator used by maior_stream.
// Chooses between the current champion and a newly arrived sample. The new
// sample wins only on a strict comparison, so on ties the earlier index stays.
// Ports:
//   cur_val / cur_idx : running champion value and its in-block index
//   new_val / new_idx : incoming sample and its in-block index
//   win_val / win_idx : surviving champion
// Parameters:
//   WIDTH    : value width
//   IDXW     : index width
//   PICK_MIN : 0 tracks the maximum, 1 tracks the minimum
module cmp_maior
  import maior_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IDXW     = idx_width(DEF_GROUP),
  parameter bit PICK_MIN = 1'b0
) (
  input  logic [WIDTH-1:0] cur_val,
  input  logic [IDXW-1:0]  cur_idx,
  input  logic [WIDTH-1:0] new_val,
  input  logic [IDXW-1:0]  new_idx,
  output logic [WIDTH-1:0] win_val,
  output logic [IDXW-1:0]  win_idx
);

  logic take_new;

  // Strict unsigned compare in the direction being tracked.
  always_comb begin
    if (PICK_MIN) take_new = (new_val < cur_val);
    else          take_new = (cur_val < new_val);
  end

  assign win_val = take_new ? new_val : cur_val;
  assign win_idx = take_new ? new_idx : cur_idx;

endmodule

// File: rtl/maior_stream.sv
// maior_stream: sequential max-finder over blocks of GROUP unsigned samples.
// One comparator and a counter replace a parallel comparator tree. Each
// completed block produces a registered (max, index) result on a
// valid/ready output; while a result waits, input is accepted only when the
// same edge also drains the result (zero-bubble hand-over).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : sample handshake, in_data is the sample
//   out_valid/out_ready  : result handshake
//   out_max / out_idx    : block maximum and its position 0..GROUP-1
//   out_min / out_min_idx: block minimum and position (only with MAIOR_STREAM_MIN_EN)
// Configuration macro: MAIOR_STREAM_MIN_EN adds parallel minimum tracking.
module maior_stream
  import maior_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP,
  parameter int IDXW  = idx_width(GROUP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx
`ifdef MAIOR_STREAM_MIN_EN
  ,
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_min_idx
`endif
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GROUP - 1);

  state_t           state;
  logic [IDXW-1:0]  count;
  logic [WIDTH-1:0] run_max;
  logic [IDXW-1:0]  run_idx;
  logic [WIDTH-1:0] max_win_val;
  logic [IDXW-1:0]  max_win_idx;
  logic [WIDTH-1:0] cand_max;
  logic [IDXW-1:0]  cand_idx;
  logic             in_fire;
  logic             out_fire;
  logic             first;
  logic             last;

  // In HOLD the input is only open when the pending result leaves on the same edge.
  assign out_valid = (state == HOLD);
  assign in_ready  = (state == ACCUM) || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign first     = (count == '0);
  assign last      = (count == LAST_IDX);

  cmp_maior #(
    .WIDTH    (WIDTH),
    .IDXW     (IDXW),
    .PICK_MIN (1'b0)
  ) u_cmp_max (
    .cur_val (run_max),
    .cur_idx (run_idx),
    .new_val (in_data),
    .new_idx (count),
    .win_val (max_win_val),
    .win_idx (max_win_idx)
  );

  // The first sample of a block ignores whatever the running registers hold.
  assign cand_max = first ? in_data : max_win_val;
  assign cand_idx = first ? '0      : max_win_idx;

  // Controller and max tracking. The last sample of a block goes straight
  // into the output registers, so the result appears one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACCUM;
      count   <= '0;
      run_max <= '0;
      run_idx <= '0;
      out_max <= '0;
      out_idx <= '0;
    end else begin
      if (in_fire) begin
        if (last) begin
          out_max <= cand_max;
          out_idx <= cand_idx;
          count   <= '0;
          state   <= HOLD;
        end else begin
          run_max <= cand_max;
          run_idx <= cand_idx;
          count   <= count + IDXW'(1);
          state   <= ACCUM;
        end
      end else if (out_fire) begin
        state <= ACCUM;
      end
    end
  end

`ifdef MAIOR_STREAM_MIN_EN
  logic [WIDTH-1:0] run_min;
  logic [IDXW-1:0]  run_min_idx;
  logic [WIDTH-1:0] min_win_val;
  logic [IDXW-1:0]  min_win_idx;
  logic [WIDTH-1:0] cand_min;
  logic [IDXW-1:0]  cand_min_idx;

  cmp_maior #(
    .WIDTH    (WIDTH),
    .IDXW     (IDXW),
    .PICK_MIN (1'b1)
  ) u_cmp_min (
    .cur_val (run_min),
    .cur_idx (run_min_idx),
    .new_val (in_data),
    .new_idx (count),
    .win_val (min_win_val),
    .win_idx (min_win_idx)
  );

  assign cand_min     = first ? in_data : min_win_val;
  assign cand_min_idx = first ? '0      : min_win_idx;

  // Minimum tracking follows exactly the same load/hold timing as the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min     <= '0;
      run_min_idx <= '0;
      out_min     <= '0;
      out_min_idx <= '0;
    end else if (in_fire) begin
      if (last) begin
        out_min     <= cand_min;
        out_min_idx <= cand_min_idx;
      end else begin
        run_min     <= cand_min;
        run_min_idx <= cand_min_idx;
      end
    end
  end
`endif

endmodule
